// File: rtl/mole_pkg.sv
// Shared types and geometry helpers for the mole field.
//   mole_state_e : per-hole lifecycle state (IDLE, RISE, UP, FALL, HIT)
//   hole_x0/y0   : top-left pixel of a hole from its index and grid geometry
package mole_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RISE = 3'd1,
    UP   = 3'd2,
    FALL = 3'd3,
    HIT  = 3'd4
  } mole_state_e;

  function automatic int hole_x0(input int idx, input int cols, input int origin, input int pitch);
    return origin + (idx % cols) * pitch;
  endfunction

  function automatic int hole_y0(input int idx, input int cols, input int origin, input int pitch);
    return origin + (idx / cols) * pitch;
  endfunction

endpackage

// File: rtl/mole_hole_fsm.sv
// Lifecycle of a single hole: rise, stay up, fall, or show the hit animation.
// Ports:
//   Clk, RESET      : clock, synchronous active-high reset
//   frame_tick      : advances timers and height
//   spawn_grant     : start rising (only honoured while IDLE)
//   hit_grant       : enter HIT; overrides any same-cycle timer step or expiry
//   state           : current lifecycle state
//   height          : rise height, 0 = hidden, RISE_FRAMES = fully up
//   hittable        : UP, or RISE at least half way up
module mole_hole_fsm
  import mole_pkg::*;
#(
  parameter int RISE_FRAMES = 16,
  parameter int UP_FRAMES   = 60,
  parameter int HIT_FRAMES  = 20
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic        frame_tick,
  input  logic        spawn_grant,
  input  logic        hit_grant,
  output mole_state_e state,
  output logic [4:0]  height,
  output logic        hittable
);

  localparam int TIMER_MAX = (UP_FRAMES > HIT_FRAMES) ? UP_FRAMES : HIT_FRAMES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  localparam logic [4:0]         RISE_TOP = 5'(RISE_FRAMES);
  localparam logic [4:0]         HALF_UP  = 5'(RISE_FRAMES / 2);
  localparam logic [TIMER_W-1:0] UP_LOAD  = TIMER_W'(UP_FRAMES);
  localparam logic [TIMER_W-1:0] HIT_LOAD = TIMER_W'(HIT_FRAMES);
  localparam logic [TIMER_W-1:0] T_ONE    = TIMER_W'(1);

  mole_state_e          state_reg, state_next;
  logic [4:0]           height_reg, height_next;
  logic [TIMER_W-1:0]   timer_reg, timer_next;

  always_ff @(posedge Clk) begin
    if (RESET) begin
      state_reg  <= IDLE;
      height_reg <= '0;
      timer_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      height_reg <= height_next;
      timer_reg  <= timer_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    height_next = height_reg;
    timer_next  = timer_reg;
    if (hit_grant) begin
      // Height stays frozen so the sprite shows the hit at the height it was struck.
      state_next = HIT;
      timer_next = HIT_LOAD;
    end else begin
      case (state_reg)
        IDLE: begin
          if (spawn_grant) begin
            state_next  = RISE;
            height_next = '0;
            timer_next  = '0;
          end
        end
        RISE: begin
          if (frame_tick) begin
            height_next = height_reg + 5'd1;
            if (height_reg == RISE_TOP - 5'd1) begin
              state_next = UP;
              timer_next = UP_LOAD;
            end
          end
        end
        UP: begin
          // Leaving on the tick that would reach zero gives exactly UP_FRAMES ticks in UP.
          if (frame_tick) begin
            if (timer_reg <= T_ONE) begin
              state_next = FALL;
              timer_next = '0;
            end else begin
              timer_next = timer_reg - T_ONE;
            end
          end
        end
        FALL: begin
          if (frame_tick) begin
            if (height_reg <= 5'd1) begin
              state_next  = IDLE;
              height_next = '0;
            end else begin
              height_next = height_reg - 5'd1;
            end
          end
        end
        HIT: begin
          if (frame_tick) begin
            if (timer_reg <= T_ONE) begin
              state_next  = IDLE;
              height_next = '0;
              timer_next  = '0;
            end else begin
              timer_next = timer_reg - T_ONE;
            end
          end
        end
        default: begin
          state_next  = IDLE;
          height_next = '0;
          timer_next  = '0;
        end
      endcase
    end
  end

  assign state    = state_reg;
  assign height   = height_reg;
  assign hittable = (state_reg == UP) || ((state_reg == RISE) && (height_reg >= HALF_UP));

endmodule

// File: rtl/mole_field_scheduler.sv
// Whack-a-mole field: N hole lifecycles, LFSR-driven spawn scheduler with a
// concurrency cap and spawn gap, click hit-testing and a saturating score.
// Ports:
//   Clk, RESET            : clock, synchronous active-high reset
//   frame_tick            : one pulse per video frame; all timers step on it
//   round_start           : clears score and spawn gap (holes keep running)
//   round_active          : enables spawns and click scoring
//   rand_in               : free-running LFSR, low nibble picks the spawn hole
//   mouseX, mouseY, click : cursor position and left-button level
//   hole_state/height     : per-hole state and rise height for sprite drawing
//   hit_pulse/miss_pulse  : one-cycle click outcome, the cycle after the edge
//   hit_idx               : last hole hit
//   score                 : saturating hit count
//   active_count          : number of holes not IDLE
module mole_field_scheduler
  import mole_pkg::*;
#(
  parameter int N_HOLES     = 9,
  parameter int GRID_COLS   = 3,
  parameter int ORIGIN_X    = 70,
  parameter int ORIGIN_Y    = 55,
  parameter int PITCH_X     = 200,
  parameter int PITCH_Y     = 150,
  parameter int HOLE_W      = 100,
  parameter int HOLE_H      = 80,
  parameter int MAX_ACTIVE  = 2,
  parameter int RISE_FRAMES = 16,
  parameter int UP_FRAMES   = 60,
  parameter int HIT_FRAMES  = 20,
  parameter int SPAWN_GAP   = 30,
  parameter int SCORE_W     = 8
) (
  input  logic                      Clk,
  input  logic                      RESET,
  input  logic                      frame_tick,
  input  logic                      round_start,
  input  logic                      round_active,
  input  logic [15:0]               rand_in,
  input  logic [9:0]                mouseX,
  input  logic [9:0]                mouseY,
  input  logic                      click,
  output logic [N_HOLES-1:0][2:0]   hole_state,
  output logic [N_HOLES-1:0][4:0]   hole_height,
  output logic                      hit_pulse,
  output logic                      miss_pulse,
  output logic [3:0]                hit_idx,
  output logic [SCORE_W-1:0]        score,
  output logic [4:0]                active_count
);

  // +2 keeps the width non-zero even when SPAWN_GAP is 0.
  localparam int               GAP_W    = $clog2(SPAWN_GAP + 2);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(SPAWN_GAP);

  logic [GAP_W-1:0]   gap_reg;
  logic               click_q_reg;
  logic               hit_pulse_reg;
  logic               miss_pulse_reg;
  logic [3:0]         hit_idx_reg;
  logic [SCORE_W-1:0] score_reg;

  mole_state_e        state_w [N_HOLES];
  logic [N_HOLES-1:0] hittable_w;
  logic [N_HOLES-1:0] in_box_w;
  logic [N_HOLES-1:0] spawn_grant_w;
  logic [N_HOLES-1:0] hit_grant_w;

  logic [15:0] idle_vec;
  logic [4:0]  active_cnt;
  logic [3:0]  cand;
  logic        cand_ok;
  logic        spawn_fire;
  logic        click_edge;
  logic        click_valid;
  logic        hit_found;
  logic [3:0]  hit_sel;
  logic        unused_rand;

  assign unused_rand = ^rand_in[15:4];

  for (genvar gi = 0; gi < N_HOLES; gi++) begin : g_hole
    localparam int         X0   = hole_x0(gi, GRID_COLS, ORIGIN_X, PITCH_X);
    localparam int         Y0   = hole_y0(gi, GRID_COLS, ORIGIN_Y, PITCH_Y);
    localparam logic [15:0] X_LO = 16'(X0);
    localparam logic [15:0] X_HI = 16'(X0 + HOLE_W);
    localparam logic [15:0] Y_LO = 16'(Y0);
    localparam logic [15:0] Y_HI = 16'(Y0 + HOLE_H);

    assign in_box_w[gi] = ({6'd0, mouseX} >= X_LO) && ({6'd0, mouseX} < X_HI) &&
                          ({6'd0, mouseY} >= Y_LO) && ({6'd0, mouseY} < Y_HI);

    assign spawn_grant_w[gi] = spawn_fire && (cand == 4'(gi));
    assign hit_grant_w[gi]   = click_valid && hit_found && (hit_sel == 4'(gi));

    mole_hole_fsm #(
      .RISE_FRAMES (RISE_FRAMES),
      .UP_FRAMES   (UP_FRAMES),
      .HIT_FRAMES  (HIT_FRAMES)
    ) u_fsm (
      .Clk         (Clk),
      .RESET       (RESET),
      .frame_tick  (frame_tick),
      .spawn_grant (spawn_grant_w[gi]),
      .hit_grant   (hit_grant_w[gi]),
      .state       (state_w[gi]),
      .height      (hole_height[gi]),
      .hittable    (hittable_w[gi])
    );

    assign hole_state[gi] = state_w[gi];
  end

  // Holes beyond N_HOLES read as not idle so an out-of-range candidate never spawns.
  always_comb begin
    idle_vec   = '0;
    active_cnt = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      idle_vec[i] = (state_w[i] == IDLE);
      if (state_w[i] != IDLE) active_cnt = active_cnt + 5'd1;
    end
  end

  assign cand       = rand_in[3:0];
  assign cand_ok    = idle_vec[cand] && ({1'b0, cand} < 5'(N_HOLES));
  assign spawn_fire = frame_tick && (gap_reg == '0) && round_active &&
                      (active_cnt < 5'(MAX_ACTIVE)) && cand_ok;

  // Scanning downward leaves the lowest-index candidate as the winner.
  always_comb begin
    hit_found = 1'b0;
    hit_sel   = '0;
    for (int i = N_HOLES - 1; i >= 0; i--) begin
      if (hittable_w[i] && in_box_w[i]) begin
        hit_found = 1'b1;
        hit_sel   = 4'(i);
      end
    end
  end

  assign click_edge  = click && !click_q_reg;
  assign click_valid = click_edge && round_active;

  always_ff @(posedge Clk) begin
    if (RESET) begin
      gap_reg        <= '0;
      click_q_reg    <= 1'b0;
      hit_pulse_reg  <= 1'b0;
      miss_pulse_reg <= 1'b0;
      hit_idx_reg    <= '0;
      score_reg      <= '0;
    end else begin
      click_q_reg    <= click;
      hit_pulse_reg  <= click_valid && hit_found;
      miss_pulse_reg <= click_valid && !hit_found;
      if (click_valid && hit_found) hit_idx_reg <= hit_sel;

      if (round_start)
        score_reg <= '0;
      else if (click_valid && hit_found && (score_reg != '1))
        score_reg <= score_reg + SCORE_W'(1);

      // A grant in the same cycle as round_start still loads the gap so spawns stay spaced.
      if (spawn_fire)
        gap_reg <= GAP_LOAD;
      else if (round_start)
        gap_reg <= '0;
      else if (frame_tick && (gap_reg != '0))
        gap_reg <= gap_reg - GAP_W'(1);
    end
  end

  assign hit_pulse    = hit_pulse_reg;
  assign miss_pulse   = miss_pulse_reg;
  assign hit_idx      = hit_idx_reg;
  assign score        = score_reg;
  assign active_count = active_cnt;

endmodule

// File: tb/tb_mole_field_scheduler.sv
// Self-checking bench for mole_field_scheduler. The reference model describes
// each mole by the frame tick it was spawned or hit on and derives state and
// height from elapsed ticks; every cycle all outputs are compared.
module tb_mole_field_scheduler;
  import mole_pkg::*;

  localparam int N    = 9;
  localparam int COLS = 3;
  localparam int OX   = 70;
  localparam int OY   = 55;
  localparam int PX   = 200;
  localparam int PY   = 150;
  localparam int HW   = 100;
  localparam int HH   = 80;
  localparam int MAXA = 2;
  localparam int RF   = 16;
  localparam int UPF  = 60;
  localparam int HITF = 20;
  localparam int GAP  = 30;
  localparam int SMAX = 255;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic              RESET, frame_tick, round_start, round_active, click;
  logic [15:0]       rand_in;
  logic [9:0]        mouseX, mouseY;
  logic [N-1:0][2:0] hole_state;
  logic [N-1:0][4:0] hole_height;
  logic              hit_pulse, miss_pulse;
  logic [3:0]        hit_idx;
  logic [7:0]        score;
  logic [4:0]        active_count;

  mole_field_scheduler dut (
    .Clk(Clk), .RESET(RESET), .frame_tick(frame_tick), .round_start(round_start),
    .round_active(round_active), .rand_in(rand_in), .mouseX(mouseX), .mouseY(mouseY),
    .click(click), .hole_state(hole_state), .hole_height(hole_height),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .hit_idx(hit_idx),
    .score(score), .active_count(active_count)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0 = never spawned, 1 = spawned at born[], 2 = hit at born[].
  int tick_cnt = 0;
  int mode   [N];
  int born   [N];
  int frozen [N];
  int last_spawn = -1000;
  int m_score = 0;
  int m_hit_idx = 0;
  bit prev_click = 0;
  bit exp_hit = 0;
  bit exp_miss = 0;

  function automatic int m_state(input int i);
    int e;
    e = tick_cnt - born[i];
    if (mode[i] == 1) begin
      if (e < RF)            return int'(RISE);
      if (e < RF + UPF)      return int'(UP);
      if (e < 2 * RF + UPF)  return int'(FALL);
      return int'(IDLE);
    end
    if (mode[i] == 2) return (e < HITF) ? int'(HIT) : int'(IDLE);
    return int'(IDLE);
  endfunction

  function automatic int m_height(input int i);
    int e;
    e = tick_cnt - born[i];
    if (mode[i] == 1) begin
      if (e < RF)            return e;
      if (e < RF + UPF)      return RF;
      if (e < 2 * RF + UPF)  return 2 * RF + UPF - e;
      return 0;
    end
    if (mode[i] == 2) return (e < HITF) ? frozen[i] : 0;
    return 0;
  endfunction

  function automatic bit m_hittable(input int i);
    return (m_state(i) == int'(UP)) || (m_state(i) == int'(RISE) && m_height(i) >= RF / 2);
  endfunction

  function automatic int m_active();
    int c;
    c = 0;
    for (int i = 0; i < N; i++) if (m_state(i) != int'(IDLE)) c++;
    return c;
  endfunction

  function automatic int hx(input int i); return OX + (i % COLS) * PX; endfunction
  function automatic int hy(input int i); return OY + (i / COLS) * PY; endfunction

  function automatic bit m_in_box(input int i, input int mx, input int my);
    return (mx >= hx(i)) && (mx < hx(i) + HW) && (my >= hy(i)) && (my < hy(i) + HH);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: model the edge from the inputs currently driven, then compare all outputs.
  task automatic cyc();
    bit edge_now;
    int hi, sp, nt, act, cnd;
    int hh [N];
    logic [N*3-1:0] es;
    logic [N*5-1:0] eh;
    if (RESET) begin
      @(posedge Clk);
      for (int i = 0; i < N; i++) mode[i] = 0;
      last_spawn = -1000;
      m_score = 0;
      m_hit_idx = 0;
      prev_click = 0;
      exp_hit = 0;
      exp_miss = 0;
    end else begin
      edge_now = click && !prev_click;
      hi = -1;
      if (edge_now && round_active)
        for (int i = 0; i < N; i++)
          if (hi < 0 && m_hittable(i) && m_in_box(i, int'(mouseX), int'(mouseY))) hi = i;
      act = m_active();
      nt  = tick_cnt + (frame_tick ? 1 : 0);
      cnd = int'(rand_in[3:0]);
      sp  = -1;
      if (frame_tick && (nt - last_spawn > GAP) && round_active && act < MAXA && cnd < N)
        if (m_state(cnd) == int'(IDLE)) sp = cnd;
      for (int i = 0; i < N; i++) hh[i] = m_height(i);
      @(posedge Clk);
      exp_hit  = edge_now && round_active && (hi >= 0);
      exp_miss = edge_now && round_active && (hi < 0);
      if (exp_hit) m_hit_idx = hi;
      if (round_start) m_score = 0;
      else if (exp_hit && m_score < SMAX) m_score++;
      if (sp >= 0) last_spawn = nt;
      else if (round_start) last_spawn = -1000;
      tick_cnt = nt;
      if (exp_hit) begin
        mode[hi] = 2; born[hi] = tick_cnt; frozen[hi] = hh[hi];
      end
      if (sp >= 0) begin
        mode[sp] = 1; born[sp] = tick_cnt;
      end
      prev_click = click;
    end
    #1;
    for (int i = 0; i < N; i++) begin
      es[i*3 +: 3] = 3'(m_state(i));
      eh[i*5 +: 5] = 5'(m_height(i));
    end
    check("hole_state",   64'(hole_state),   64'(es));
    check("hole_height",  64'(hole_height),  64'(eh));
    check("hit_pulse",    64'(hit_pulse),    64'(exp_hit));
    check("miss_pulse",   64'(miss_pulse),   64'(exp_miss));
    check("hit_idx",      64'(hit_idx),      64'(m_hit_idx));
    check("score",        64'(score),        64'(m_score));
    check("active_count", 64'(active_count), 64'(m_active()));
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1; cyc();
      frame_tick = 1'b0; cyc();
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1; cyc();
    RESET = 1'b0;
  endtask

  task automatic click_at(input int x, input int y);
    mouseX = 10'(x); mouseY = 10'(y);
    click = 1'b1; cyc();
  endtask

  initial begin
    int pick, cycles, j;
    RESET = 1'b1; frame_tick = 0; round_start = 0; round_active = 0; click = 0;
    rand_in = '0; mouseX = '0; mouseY = '0;
    cyc();
    cyc();
    RESET = 1'b0;
    check("reset_score",  64'(score), 64'(0));
    check("reset_active", 64'(active_count), 64'(0));

    // 100 frames with the round inactive: nothing spawns, clicks produce no pulse.
    for (int k = 0; k < 100; k++) begin
      rand_in = 16'($urandom);
      if (k % 10 == 0) begin
        j = $urandom_range(0, N - 1);
        click_at(hx(j) + 20, hy(j) + 20);
        click = 0;
      end
      frames(1);
    end
    check("idle_active", 64'(active_count), 64'(0));
    check("idle_score",  64'(score), 64'(0));

    // Hole 4 lifecycle and spawn gap against hole 5.
    round_active = 1; rand_in = 16'd4;
    frames(1);
    check("h4_rise",   64'(hole_state[4]), 64'(RISE));
    rand_in = 16'd5;
    frames(16);
    check("h4_up",     64'(hole_state[4]), 64'(UP));
    check("h4_top",    64'(hole_height[4]), 64'(16));
    frames(14);
    check("h5_gap",    64'(hole_state[5]), 64'(IDLE));
    frames(1);
    check("h5_spawn",  64'(hole_state[5]), 64'(RISE));
    rand_in = 16'd15;
    frames(44);
    check("h4_up_end", 64'(hole_state[4]), 64'(UP));
    frames(1);
    check("h4_fall",   64'(hole_state[4]), 64'(FALL));
    frames(16);
    check("h4_idle",   64'(hole_state[4]), 64'(IDLE));

    // Hit on hole 4 while UP.
    do_reset();
    round_active = 1; rand_in = 16'd4;
    frames(1);
    rand_in = 16'd15;
    frames(20);
    click_at(280, 215);
    check("hit_pulse_dir", 64'(hit_pulse), 64'(1));
    check("hit_idx_dir",   64'(hit_idx),   64'(4));
    check("hit_score_dir", 64'(score),     64'(1));
    check("hit_state_dir", 64'(hole_state[4]), 64'(HIT));
    click = 0; cyc();
    frames(19);
    check("hit_hold",  64'(hole_state[4]), 64'(HIT));
    frames(1);
    check("hit_done",  64'(hole_state[4]), 64'(IDLE));

    // Misses: empty spot, then hole 4 only 5 high.
    click_at(0, 0);
    check("miss_empty", 64'(miss_pulse), 64'(1));
    click = 0; cyc();
    rand_in = 16'd4;
    frames(1);
    rand_in = 16'd15;
    frames(5);
    check("low_height", 64'(hole_height[4]), 64'(5));
    click_at(280, 215);
    check("miss_low",   64'(miss_pulse), 64'(1));
    check("miss_score", 64'(score), 64'(1));
    click = 0; cyc();

    // Concurrency cap with rand cycling 0,1,2.
    do_reset();
    round_active = 1;
    for (int k = 0; k < 120; k++) begin
      rand_in = 16'(k % 3);
      frames(1);
      check("cap_active", 64'(active_count <= 5'd2), 64'(1));
    end

    // Out-of-range candidate retries every tick without loading the gap.
    do_reset();
    round_active = 1; rand_in = 16'd12;
    frames(3);
    check("oob_none", 64'(active_count), 64'(0));
    rand_in = 16'd7;
    frames(1);
    check("oob_retry", 64'(hole_state[7]), 64'(RISE));

    // Randomized traffic.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      frame_tick   = ($urandom_range(0, 2) == 0);
      rand_in      = 16'($urandom);
      round_active = ($urandom_range(0, 15) != 0);
      round_start  = ($urandom_range(0, 199) == 0);
      click        = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) begin
        j = $urandom_range(0, N - 1);
        mouseX = 10'(hx(j) - 5 + $urandom_range(0, HW + 10));
        mouseY = 10'(hy(j) - 5 + $urandom_range(0, HH + 10));
      end else begin
        mouseX = 10'($urandom_range(0, 639));
        mouseY = 10'($urandom_range(0, 479));
      end
      cyc();
    end
    frame_tick = 0; round_start = 0; click = 0; cyc();

    // Drive the score to saturation by clicking whatever the model says is hittable.
    do_reset();
    round_active = 1; frame_tick = 1;
    cycles = 0;
    while (m_score < SMAX && cycles < 40000) begin
      rand_in = 16'($urandom_range(0, N - 1));
      if (click) click = 0;
      else begin
        pick = -1;
        for (int i = 0; i < N; i++) if (pick < 0 && m_hittable(i)) pick = i;
        if (pick >= 0) begin
          mouseX = 10'(hx(pick) + 10); mouseY = 10'(hy(pick) + 10); click = 1;
        end
      end
      cyc();
      cycles++;
    end
    check("sat_reached", 64'(score), 64'(SMAX));
    pick = -1;
    cycles = 0;
    while (pick < 0 && cycles < 2000) begin
      rand_in = 16'($urandom_range(0, N - 1));
      click = 0;
      for (int i = 0; i < N; i++) if (pick < 0 && m_hittable(i)) pick = i;
      if (pick >= 0) begin
        mouseX = 10'(hx(pick) + 10); mouseY = 10'(hy(pick) + 10); click = 1;
      end
      cyc();
      cycles++;
    end
    check("sat_hit",   64'(hit_pulse), 64'(1));
    check("sat_score", 64'(score), 64'(SMAX));
    click = 0;
    round_start = 1; cyc();
    round_start = 0;
    check("rs_score", 64'(score), 64'(0));
    cyc();

    // Reset in the middle of a rise.
    frame_tick = 0;
    do_reset();
    round_active = 1; rand_in = 16'd2;
    frames(4);
    check("pre_rst_rise", 64'(hole_state[2]), 64'(RISE));
    do_reset();
    check("rst_states",  64'(hole_state),  64'(0));
    check("rst_heights", 64'(hole_height), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mole_field_scheduler.md
Name: mole_field_scheduler

Overview:
- Parametrised successor to the fixed nine-hole whack-a-mole core.
- Owns N independent hole lifecycles, an LFSR-fed spawn scheduler with a concurrency cap, click hit-testing against a parametric hole grid, and a saturating score counter.
- Sits between the mouse/VGA front end and the color mapper/score board. Exports per-hole state and rise height for sprite drawing.

Parameters:
- N_HOLES, 9, number of holes (1..16).
- GRID_COLS, 3, holes per row; hole i is at col = i % GRID_COLS, row = i / GRID_COLS.
- ORIGIN_X / ORIGIN_Y, 70 / 55, top-left pixel of hole 0.
- PITCH_X / PITCH_Y, 200 / 150, pixel spacing between hole origins.
- HOLE_W / HOLE_H, 100 / 80, hit box size in pixels.
- MAX_ACTIVE, 2, maximum number of holes not in IDLE at once.
- RISE_FRAMES, 16, frames to rise and frames to fall.
- UP_FRAMES, 60, frames the mole stays fully up.
- HIT_FRAMES, 20, frames the hit animation is shown.
- SPAWN_GAP, 30, minimum frames between spawns.
- SCORE_W, 8, score width.

Ports:
- Clk, in, 1, system clock.
- RESET, in, 1, synchronous, active-high.
- frame_tick, in, 1, one-Clk pulse per video frame.
- round_start, in, 1, pulse that clears the score and spawn gap.
- round_active, in, 1, spawns are allowed only while high.
- rand_in, in, 16, free-running LFSR value.
- mouseX / mouseY, in, 10 each, cursor position.
- click, in, 1, left-button level.
- hole_state, out, N_HOLES x 3, per-hole mole_state_e.
- hole_height, out, N_HOLES x 5, 0..RISE_FRAMES, 0 = hidden.
- hit_pulse / miss_pulse, out, 1 each, one-Clk pulse per click outcome.
- hit_idx, out, 4, index of the last hit hole.
- score, out, SCORE_W, saturating hit count.
- active_count, out, 5, number of non-IDLE holes.

Behaviour:
- Reset values: all holes IDLE with height 0; score 0; pulses 0; hit_idx 0; active_count 0; spawn gap counter 0; click edge register 0.
- Per-hole FSM; all timers advance only on frame_tick.
  - IDLE -> RISE on spawn_grant[i].
  - RISE: height +1 per tick. At height == RISE_FRAMES -> UP with timer = UP_FRAMES.
  - UP: timer -1 per tick. At 0 -> FALL.
  - FALL: height -1 per tick. At 0 -> IDLE.
  - HIT: entered on hit_grant[i] with timer = HIT_FRAMES and height frozen. At timer 0 -> IDLE with height 0.
- Hittable = (state == UP) or (state == RISE and height >= RISE_FRAMES/2).
- Hit-grant vs. same-cycle expiry: hit wins.
- Spawn scheduler, evaluated on frame_tick:
  - If gap counter > 0, decrement it.
  - Else, if round_active and active_count < MAX_ACTIVE: cand = rand_in[3:0].
    - If cand < N_HOLES and hole cand is IDLE: grant the spawn and load gap = SPAWN_GAP.
    - Otherwise no grant and the gap stays 0, so it retries next tick.
  - At most one spawn per tick.
  - With N_HOLES = 16 every cand is valid.
- Click handling:
  - Rising edge = click & ~click_q, registered one cycle.
  - Hit test runs against the hole states before any same-cycle frame_tick update.
  - The lowest-index hittable hole whose box contains the cursor is granted. Containment: mouseX in [x0, x0+HOLE_W) and mouseY in [y0, y0+HOLE_H).
  - Exactly one of hit_pulse or miss_pulse fires, in the cycle after the edge; hit_idx updates on a hit.
  - A click edge while round_active is low fires no pulse.
- Score: +1 on each hit and saturates at all-ones. round_start clears the score and the gap counter only; holes continue.
- Falling round_active: no new spawns; in-flight moles finish their lifecycle.
- RESET mid-operation returns everything to reset values on the next edge.
- Same-cycle frame_tick and click edge: both are processed. A hole granted a hit does not also take a timer step that cycle.

Decomposition:
- mole_pkg holds:
  - typedef enum logic [2:0] mole_state_e: IDLE, RISE, UP, FALL, HIT.
  - Localparam helper functions hole_x0(i) and hole_y0(i).
- Sub-module mole_hole_fsm: one instance per hole via generate. Contains the timer, height and state, and exposes a hittable output.
- The scheduler, hit arbiter and score counter stay in the top level.

Test Plan:
- Reset, then 100 frames with round_active = 0: all IDLE, score 0, no pulses, active_count 0.
- round_active = 1, rand_in forced to 4: hole 4 rises.
  - Height 16 after 16 ticks.
  - UP for 60 ticks, FALL for 16 ticks, then IDLE.
  - Next spawn no earlier than 30 ticks after the first.
- Hole 4 in UP, cursor at (280,215) with hole 4 origin (270,205), click: hit_pulse in the cycle after the edge, hit_idx = 4, score = 1, HIT for 20 ticks, then IDLE.
- Click at (0,0), and a click on hole 4 while its RISE height is 5: each gives miss_pulse, score unchanged.
- MAX_ACTIVE = 2, rand_in cycling 0,1,2: third spawn is withheld until one hole returns to IDLE. rand_in = 12 with N_HOLES = 9: no grant, retried the next tick.
- Score preloaded to 255, then a hit: score stays 255. round_start pulse: score 0 and holes unchanged. RESET asserted during a RISE: all holes IDLE on the next Clk.
